// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops (AND, XOR, SLL, ADD, SUB, ADDI, SRAI) retire one cycle after accept.
// MUL runs an iterative shift-add multiplier that returns the low WIDTH bits of the product.
// Optional build macro: ALU_MUL_RADIX4_EN.
// When it is defined, the multiplier retires two multiplier bits per cycle,
// so MUL latency drops to WIDTH/2 cycles.
// When it is undefined, the multiplier is radix-2 with a latency of WIDTH cycles.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       ALUCtr_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

`ifdef ALU_MUL_RADIX4_EN
    localparam int MUL_ITERS = WIDTH / 2;
`else
    localparam int MUL_ITERS = WIDTH;
`endif
    // Counter value on the edge that performs the final multiply iteration.
    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(MUL_ITERS - 1);
    localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};

    state_t             state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_r;
    logic [SHAMT_W-1:0] count_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               valid_r;
    logic               busy_r;

    logic               ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]   mcand_next_s;
    logic [WIDTH-1:0]   mplier_next_s;
    logic [WIDTH-1:0]   addend0_s;
`ifdef ALU_MUL_RADIX4_EN
    logic [WIDTH-1:0]   addend1_s;
`endif

    // Single-cycle datapath. MUL never takes this path, so it yields zero here.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHAMT_W-1:0] shamt;
        shamt = b[SHAMT_W-1:0];
        case (op)
            OP_AND:  alu_single = a & b;
            OP_XOR:  alu_single = a ^ b;
            OP_SLL:  alu_single = a << shamt;
            OP_ADD:  alu_single = a + b;
            OP_SUB:  alu_single = a - b;
            OP_ADDI: alu_single = a + b;
            OP_SRAI: alu_single = WIDTH'($signed(a) >>> shamt);
            default: alu_single = {WIDTH{1'b0}};
        endcase
    endfunction

    assign ready_s  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready_i);
    assign accept_s = in_valid_i & ready_s;

    // Result of the single-cycle operation currently presented on the inputs.
    always_comb begin
        alu_res_s = alu_single(ALUCtr_i, data1_i, data2_i);
    end

    // Next shift-add multiplier step: add the selected partial products, then shift both operands.
    always_comb begin
        addend0_s = mplier_r[0] ? mcand_r : ZERO_W;
`ifdef ALU_MUL_RADIX4_EN
        addend1_s     = mplier_r[1] ? {mcand_r[WIDTH-2:0], 1'b0} : ZERO_W;
        acc_next_s    = acc_r + addend0_s + addend1_s;
        mcand_next_s  = {mcand_r[WIDTH-3:0], 2'b00};
        mplier_next_s = {2'b00, mplier_r[WIDTH-1:2]};
`else
        acc_next_s    = acc_r + addend0_s;
        mcand_next_s  = {mcand_r[WIDTH-2:0], 1'b0};
        mplier_next_s = {1'b0, mplier_r[WIDTH-1:1]};
`endif
    end

    // Control FSM with the registered result, valid, and busy outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
            acc_r    <= ZERO_W;
            count_r  <= {SHAMT_W{1'b0}};
            result_r <= ZERO_W;
            zero_r   <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (ALUCtr_i == OP_MUL) begin
                            state_r  <= ST_MUL;
                            mcand_r  <= data1_i;
                            mplier_r <= data2_i;
                            acc_r    <= ZERO_W;
                            count_r  <= {SHAMT_W{1'b0}};
                            valid_r  <= 1'b0;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_DONE;
                            result_r <= alu_res_s;
                            zero_r   <= (alu_res_s == ZERO_W);
                            valid_r  <= 1'b1;
                            busy_r   <= 1'b0;
                        end
                    end else if ((state_r == ST_DONE) && out_ready_i) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_next_s;
                    mplier_r <= mplier_next_s;
                    count_r  <= count_r + SHAMT_W'(1);
                    if (count_r == LAST_ITER) begin
                        state_r  <= ST_DONE;
                        result_r <= acc_next_s;
                        zero_r   <= (acc_next_s == ZERO_W);
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_s;
    assign out_valid_o = valid_r;
    assign result_o    = result_r;
    assign zero_o      = zero_r;
    assign busy_o      = busy_r;

endmodule
